wb_regfile_stage: RTL
=====================

Name: wb_regfile_stage

Overview:
- Consumer end of the ALU stage result interface: alu_result, OVF, destReg_addr_output, we_output, bp_output.
- Latches one ALU result per enabled cycle into a writeback pipeline register.
- Commits the held result into an 8 x 16-bit register file.
- Serves two combinational read ports to decode with same-cycle write bypass, and keeps a sticky overflow flag plus a wrapping commit counter.

Parameters:
- DATA_W, 16, register and result width.
- ADDR_W, 3, register address width; file depth = 2**ADDR_W.
- CNT_W, 16, commit counter width.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- enable_wb  input  1  stage advance; 1 = commit held entry and load new entry.
- alu_result  input  DATA_W  result from ALU stage.
- OVF  input  1  overflow from ALU stage.
- destReg_addr  input  ADDR_W  destination register.
- we  input  1  destination write request.
- bp_input  input  2  tag forwarded with the instruction.
- rd_addr_a  input  ADDR_W  decode read port A address.
- rd_addr_b  input  ADDR_W  decode read port B address.
- clr_ovf  input  1  clears sticky overflow flag.
- rd_data_a  output  DATA_W  port A data.
- rd_data_b  output  DATA_W  port B data.
- wb_valid_write  output  1  held entry will write on next enabled edge (wb_we_q).
- wb_dest_addr  output  ADDR_W  held entry destination, for hazard detection.
- bp_output  output  2  held entry tag.
- ovf_sticky  output  1  sticky overflow.
- commit_count  output  CNT_W  number of committed register writes.

Behaviour:
- Reset (reset=0, async):
  - WB register fields are cleared: result_q, dest_q, we_q, ovf_q, bp_q.
  - All 8 file entries are cleared.
  - ovf_sticky and commit_count are cleared.
  - All outputs read 0.
  - An entry in flight during reset is discarded and never commits.
- WB register:
  - On rising clk with enable_wb=1, loads {alu_result, OVF, destReg_addr, we, bp_input}.
  - With enable_wb=0, it holds.
- Commit condition: commit = enable_wb & we_q. It is evaluated on the held entry, which commits on the same edge that the next entry loads.
  - A stall (enable_wb=0) holds the entry uncommitted.
  - A held entry is never written twice.
- File write: on the edge where commit=1, file[dest_q] <= result_q. All addresses, including 0, are writable.
- Read ports:
  - Combinational.
  - rd_data_x = result_q if (commit & rd_addr_x == dest_q), else file[rd_addr_x]. This is write-first bypass within the commit cycle.
  - Both ports may hit the same address or the bypass simultaneously; both return the same value.
- ovf_sticky:
  - Set on an edge where commit & ovf_q.
  - Cleared on an edge where clr_ovf=1.
  - Set and clear on the same edge: set wins, so the flag stays 1.
  - Overflow of an entry with we_q=0 is ignored.
- commit_count: increments by 1 on each commit edge and wraps from 2**CNT_W-1 to 0.
- Latency:
  - Input to WB register: 1 cycle.
  - WB register to file: the next enabled edge.
  - File to read port: 0 cycles.
  - Bypass makes the value visible in the cycle before the file update.
- Back-to-back writes to the same address:
  - The older entry commits first, then the younger one.
  - The final file value is the younger result.

Test Plan:
1. Reset, then apply reset=0 mid-stream with a held entry dest=3, we=1, result=0x1234 -> after release file[3]=0, commit_count=0, ovf_sticky=0, all read data=0.
2. Load {0x00AB, dest=5, we=1} with enable_wb=1; hold enable_wb=0 for 3 cycles -> file[5] stays 0, rd_data_a(addr5)=0, commit_count=0.
   - Then enable_wb=1 for one cycle -> rd_data_a=0x00AB that cycle via bypass; file[5]=0x00AB after the edge; commit_count=1.
3. Consecutive enabled loads {0x1111, d=2}, {0x2222, d=2}, {0x3333, d=7, we=0}, {0, d=0, we=0} -> file[2]=0x2222, file[7] unchanged, commit_count=2.
4. Commit an entry with OVF=1, we=1 while clr_ovf=1 on the same edge -> ovf_sticky=1.
   - Next cycle clr_ovf=1 -> ovf_sticky=0.
   - An OVF=1 entry with we=0 -> ovf_sticky stays 0.
5. Preload commit_count to 0xFFFF via 65535 commits, then one more commit -> commit_count=0x0000.
6. Set rd_addr_a=rd_addr_b=4 during a commit of 0xBEEF to r4 (file[4] previously 0x0101) -> both ports read 0xBEEF.
   - With enable_wb=0 instead, both ports read 0x0101.

Source files
------------

// File: rtl/wb_regfile_stage.sv
// Writeback stage: one pipeline register feeding an 8x16 register file with
// bypassed combinational read ports, a sticky overflow flag and a commit counter.
module wb_regfile_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_wb,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              OVF,
  input  logic [ADDR_W-1:0] destReg_addr,
  input  logic              we,
  input  logic [1:0]        bp_input,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wb_valid_write,
  output logic [ADDR_W-1:0] wb_dest_addr,
  output logic [1:0]        bp_output,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  commit_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] dest_q;
  logic              we_q;
  logic              ovf_q;
  logic [1:0]        bp_q;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              sticky_q;
  logic [CNT_W-1:0]  count_q;
  logic              commit;

  // The held entry retires on the same edge that the next one loads.
  assign commit = enable_wb & we_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      dest_q   <= '0;
      we_q     <= 1'b0;
      ovf_q    <= 1'b0;
      bp_q     <= '0;
    end else if (enable_wb) begin
      result_q <= alu_result;
      dest_q   <= destReg_addr;
      we_q     <= we;
      ovf_q    <= OVF;
      bp_q     <= bp_input;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[dest_q] <= result_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // Setting takes priority over a same-edge clear.
      if (commit && ovf_q) begin
        sticky_q <= 1'b1;
      end else if (clr_ovf) begin
        sticky_q <= 1'b0;
      end
      if (commit) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (commit && (rd_addr_a == dest_q)) rd_data_a = result_q;
    if (commit && (rd_addr_b == dest_q)) rd_data_b = result_q;
  end

  assign wb_valid_write = we_q;
  assign wb_dest_addr   = dest_q;
  assign bp_output      = bp_q;
  assign ovf_sticky     = sticky_q;
  assign commit_count   = count_q;

endmodule
